// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
//   Groups the hazard controller's pipeline-facing signals.
//   master : pipeline side; drives stage status, observes stall/flush controls.
//   slave  : hazard controller; observes stage status, drives stall/flush controls.
//   Status  : exe_valid, fw_valid, exe_multi, exe_done, exe_redirect,
//             mem_req, mem_ack, trap
//   Control : exe_ready, exe_start, exe_flush, id_flush, if_stall, id_stall,
//             mem_stall, mem_err, stall_cycles[31:0]
interface pipe_hazard_ctrl_if;
  logic        exe_valid;
  logic        fw_valid;
  logic        exe_multi;
  logic        exe_done;
  logic        exe_redirect;
  logic        mem_req;
  logic        mem_ack;
  logic        trap;
  logic        exe_ready;
  logic        exe_start;
  logic        exe_flush;
  logic        id_flush;
  logic        if_stall;
  logic        id_stall;
  logic        mem_stall;
  logic        mem_err;
  logic [31:0] stall_cycles;

  modport master (
    output exe_valid, fw_valid, exe_multi, exe_done, exe_redirect,
           mem_req, mem_ack, trap,
    input  exe_ready, exe_start, exe_flush, id_flush, if_stall, id_stall,
           mem_stall, mem_err, stall_cycles
  );

  modport slave (
    input  exe_valid, fw_valid, exe_multi, exe_done, exe_redirect,
           mem_req, mem_ack, trap,
    output exe_ready, exe_start, exe_flush, id_flush, if_stall, id_stall,
           mem_stall, mem_err, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Pipeline hazard controller: stalls IF/ID/EXE for multi-cycle EXE units and
//   data-memory waits, flushes on taken redirects and traps, and raises a
//   memory timeout error that is treated like a trap.
// Parameters
//   FLUSH_CYCLES : cycles spent in FLUSH after a redirect or trap (1..7)
//   MEM_TIMEOUT  : MEM_WAIT cycles before mem_err fires (1..255)
// Ports
//   clk : clock, posedge
//   rst : synchronous, active-high reset
//   bus : pipe_hazard_ctrl_if.slave (stage status in, stall/flush controls out)
// Optional feature
//   PIPE_STALL_CNT_EN : when defined, stall_cycles counts id_stall cycles
//                       (saturating); otherwise stall_cycles is tied to 0.
module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_EXE_WAIT = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_FLUSH    = 2'd3
  } state_e;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TMO_LAST   = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic [7:0] tmo_q, tmo_d;
  logic       done_q, done_d;

  logic done_eff;
  logic exe_ok;
  logic new_wait;
  logic exe_ready, exe_start, exe_flush, id_flush;
  logic if_stall, id_stall, mem_stall, mem_err;

  // A done pulse seen during a memory stall is remembered in done_q.
  assign done_eff = bus.exe_done | done_q;
  assign exe_ok   = ~bus.exe_valid |
                    (bus.fw_valid & (~bus.exe_multi | done_eff));
  assign new_wait = bus.exe_valid & bus.exe_multi & bus.fw_valid & ~bus.exe_done;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    tmo_d       = tmo_q;
    done_d      = 1'b0;
    exe_ready   = 1'b0;
    exe_start   = 1'b0;
    exe_flush   = 1'b0;
    id_flush    = 1'b0;
    if_stall    = 1'b0;
    id_stall    = 1'b0;
    mem_stall   = 1'b0;
    mem_err     = 1'b0;

    if (rst) begin
      // Kill everything in flight while reset is held.
      exe_flush = 1'b1;
      id_flush  = 1'b1;
    end else if (state_q == S_FLUSH) begin
      id_flush = 1'b1;
      if (bus.trap) begin
        exe_flush   = 1'b1;
        flush_cnt_d = FLUSH_LOAD;
      end else if (flush_cnt_q == 3'd0) begin
        state_d = S_RUN;
      end else begin
        flush_cnt_d = flush_cnt_q - 3'd1;
      end
    end else begin
      mem_stall = bus.mem_req & ~bus.mem_ack;
      exe_ready = ~mem_stall & exe_ok;
      if_stall  = ~exe_ready;
      id_stall  = ~exe_ready;
      mem_err   = (state_q == S_MEM_WAIT) & mem_stall & (tmo_q == TMO_LAST);

      if (bus.trap | mem_err) begin
        exe_flush   = 1'b1;
        id_flush    = 1'b1;
        state_d     = S_FLUSH;
        flush_cnt_d = FLUSH_LOAD;
      end else if (mem_stall) begin
        // An outstanding multi-cycle op stays in EXE_WAIT; only RUN enters
        // MEM_WAIT, so the timeout only covers pure memory waits.
        unique case (state_q)
          S_RUN: begin
            state_d = S_MEM_WAIT;
            tmo_d   = 8'd0;
          end
          S_MEM_WAIT: tmo_d = tmo_q + 8'd1;
          default:    done_d = done_eff;
        endcase
      end else if ((state_q == S_EXE_WAIT) && !done_eff) begin
        state_d = S_EXE_WAIT;
      end else if ((state_q != S_EXE_WAIT) && new_wait) begin
        // Reached from RUN, or from MEM_WAIT when the op was held back by
        // the memory stall; the op is launched only once.
        state_d   = S_EXE_WAIT;
        exe_start = 1'b1;
      end else if (bus.exe_valid & bus.exe_redirect & exe_ready) begin
        // The branch itself retires, so only the younger stages are killed.
        id_flush    = 1'b1;
        state_d     = S_FLUSH;
        flush_cnt_d = FLUSH_LOAD;
      end else begin
        state_d = S_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      flush_cnt_q <= 3'd0;
      tmo_q       <= 8'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      tmo_q       <= tmo_d;
      done_q      <= done_d;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
    end else if (id_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cnt_q;
`else
  assign bus.stall_cycles = 32'd0;
`endif

  assign bus.exe_ready = exe_ready;
  assign bus.exe_start = exe_start;
  assign bus.exe_flush = exe_flush;
  assign bus.id_flush  = id_flush;
  assign bus.if_stall  = if_stall;
  assign bus.id_stall  = id_stall;
  assign bus.mem_stall = mem_stall;
  assign bus.mem_err   = mem_err;

endmodule
